// File: rtl/axil_mem_responder.sv
// axil_mem_responder
//   Responder end of the stream-based AXI-Lite-style map interface. Owns a
//   word array of N entries and serves five valid/ready channels:
//     sRA/sRA_valid/sRA_ready : read address in
//     sR/sR_valid/sR_ready    : read data out, one cycle after sRA transfer
//     sWA/sWA_valid/sWA_ready : write address in (1-entry holding register)
//     sW/sW_valid/sW_ready    : write data in (1-entry holding register)
//     sB_valid/sB_ready       : write response out (no payload)
//   clk rising edge, rst asynchronous active-high. Memory is not reset.
//   Addresses are word indices; addr >= N reads return 0 and writes are
//   dropped (the response is still issued).
//   Optional macro AXIL_MEM_RESP_EN adds sR_resp/sB_resp (2'b00 OKAY,
//   2'b10 SLVERR for out-of-range accesses).
module axil_mem_responder #(
  parameter int ADDR_N = 10,
  parameter int DATA_N = 32,
  parameter int N      = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_N-1:0] sRA,
  input  logic              sRA_valid,
  output logic              sRA_ready,
  output logic [DATA_N-1:0] sR,
  output logic              sR_valid,
  input  logic              sR_ready,
  input  logic [ADDR_N-1:0] sWA,
  input  logic              sWA_valid,
  output logic              sWA_ready,
  input  logic [DATA_N-1:0] sW,
  input  logic              sW_valid,
  output logic              sW_ready,
  output logic              sB_valid,
  input  logic              sB_ready
`ifdef AXIL_MEM_RESP_EN
  ,
  output logic [1:0]        sR_resp,
  output logic [1:0]        sB_resp
`endif
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  // One extra bit so N == 2**ADDR_N is representable in the range compare.
  localparam logic [ADDR_N:0] N_LIM = (ADDR_N+1)'(N);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_N-1:0] mem [N];

  logic [DATA_N-1:0] sr_q, sr_d;
  logic              sr_valid_q, sr_valid_d;
  logic              sb_valid_q, sb_valid_d;
  logic              wa_full_q, wa_full_d;
  logic              w_full_q, w_full_d;
  logic [ADDR_N-1:0] wa_addr_q, wa_addr_d;
  logic [DATA_N-1:0] w_data_q, w_data_d;

  logic ra_fire, wa_fire, w_fire, commit;
  logic rd_in_range, wr_in_range;
  logic [IDX_W-1:0] rd_idx, wr_idx;

  assign rd_in_range = {1'b0, sRA} < N_LIM;
  assign wr_in_range = {1'b0, wa_addr_q} < N_LIM;
  assign rd_idx      = sRA[IDX_W-1:0];
  assign wr_idx      = wa_addr_q[IDX_W-1:0];

  // Commit drains both holding registers into memory, but only when the
  // response slot is free (or being emptied this cycle).
  assign commit    = wa_full_q && w_full_q && (!sb_valid_q || sB_ready);
  assign sRA_ready = !sr_valid_q || sR_ready;
  assign sWA_ready = !wa_full_q || commit;
  assign sW_ready  = !w_full_q || commit;

  assign ra_fire = sRA_valid && sRA_ready;
  assign wa_fire = sWA_valid && sWA_ready;
  assign w_fire  = sW_valid && sW_ready;

  assign sR       = sr_q;
  assign sR_valid = sr_valid_q;
  assign sB_valid = sb_valid_q;

  always_comb begin
    sr_d       = sr_q;
    sr_valid_d = sr_valid_q && !sR_ready;
    if (ra_fire) begin
      // Combinational array read sees pre-edge contents, so a read accepted
      // on the commit edge returns the old word.
      sr_d       = rd_in_range ? mem[rd_idx] : '0;
      sr_valid_d = 1'b1;
    end
    sb_valid_d = commit || (sb_valid_q && !sB_ready);
    // A holding register stays full unless committed, and refills on fire.
    wa_full_d  = wa_fire || (wa_full_q && !commit);
    w_full_d   = w_fire  || (w_full_q && !commit);
    wa_addr_d  = wa_fire ? sWA : wa_addr_q;
    w_data_d   = w_fire  ? sW  : w_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q       <= '0;
      sr_valid_q <= 1'b0;
      sb_valid_q <= 1'b0;
      wa_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      wa_addr_q  <= '0;
      w_data_q   <= '0;
    end else begin
      sr_q       <= sr_d;
      sr_valid_q <= sr_valid_d;
      sb_valid_q <= sb_valid_d;
      wa_full_q  <= wa_full_d;
      w_full_q   <= w_full_d;
      wa_addr_q  <= wa_addr_d;
      w_data_q   <= w_data_d;
    end
  end

  // Commit is low during reset (holding flags cleared), so a pending entry
  // never produces a partial write.
  always_ff @(posedge clk) begin
    if (commit && wr_in_range) mem[wr_idx] <= w_data_q;
  end

`ifdef AXIL_MEM_RESP_EN
  logic [1:0] sr_resp_q, sr_resp_d;
  logic [1:0] sb_resp_q, sb_resp_d;

  always_comb begin
    sr_resp_d = sr_resp_q;
    sb_resp_d = sb_resp_q;
    if (ra_fire) sr_resp_d = rd_in_range ? RESP_OKAY : RESP_SLVERR;
    if (commit)  sb_resp_d = wr_in_range ? RESP_OKAY : RESP_SLVERR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_resp_q <= 2'b00;
      sb_resp_q <= 2'b00;
    end else begin
      sr_resp_q <= sr_resp_d;
      sb_resp_q <= sb_resp_d;
    end
  end

  assign sR_resp = sr_resp_q;
  assign sB_resp = sb_resp_q;
`endif

endmodule
